rr_grant_arbiter: RTL and testbench



---
 rtl/rr_grant_arbiter.sv | 154 +++++++++++++++
 tb/tb_rr_grant_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, a binary owner index and
// a hold-timeout that preempts an owner who keeps the resource too long.
module rr_grant_arbiter #(
    parameter int SEL_WIDTH  = 2,
    parameter int MAX_HOLD   = 16,
    parameter int HOLD_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [(1<<SEL_WIDTH)-1:0] req,
    input  logic                      release_i,
    output logic [(1<<SEL_WIDTH)-1:0] grant,
    output logic [SEL_WIDTH-1:0]      grant_idx,
    output logic                      grant_valid,
    output logic                      preempt
);

    localparam int N = 1 << SEL_WIDTH;
    localparam logic [HOLD_WIDTH-1:0] MAX_HOLD_C = HOLD_WIDTH'(MAX_HOLD);
    localparam logic [HOLD_WIDTH-1:0] HOLD_SAT_C = {HOLD_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [SEL_WIDTH-1:0]   ptr_r, ptr_nxt_s;
    logic [HOLD_WIDTH-1:0]  hold_r, hold_nxt_s;
    logic [SEL_WIDTH-1:0]   idx_r, idx_nxt_s;
    logic                   valid_r, valid_nxt_s;
    logic [N-1:0]           grant_r, grant_nxt_s;
    logic                   preempt_r, preempt_nxt_s;
    logic                   timeout_s;
    logic                   end_s;
    logic [SEL_WIDTH-1:0]   scan_start_s;
    logic [SEL_WIDTH:0]     pick_s;

    // Returns {found, index} of the first requester at or after start, wrapping mod N.
    function automatic logic [SEL_WIDTH:0] pick_winner(input logic [N-1:0] req_v,
                                                      input logic [SEL_WIDTH-1:0] start);
        logic [SEL_WIDTH:0]   res;
        logic [SEL_WIDTH-1:0] cand;
        res = {(SEL_WIDTH+1){1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            cand = start + SEL_WIDTH'(k);
            if (req_v[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Tenure end detection and winner scan; the scan restarts after the owner on tenure end.
    always_comb begin
        timeout_s    = (MAX_HOLD != 0) && (hold_r == MAX_HOLD_C);
        end_s        = (state_r == BUSY) && (release_i || timeout_s);
        scan_start_s = ptr_r;
        if (end_s) begin
            scan_start_s = idx_r + 1'b1;
        end else begin
            scan_start_s = ptr_r;
        end
        pick_s = pick_winner(req, scan_start_s);
    end

    // Next-state logic for the arbitration FSM, pointer and hold counter.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        hold_nxt_s    = hold_r;
        idx_nxt_s     = idx_r;
        valid_nxt_s   = valid_r;
        preempt_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_s[SEL_WIDTH]) begin
                    state_nxt_s = BUSY;
                    idx_nxt_s   = pick_s[SEL_WIDTH-1:0];
                    valid_nxt_s = 1'b1;
                    hold_nxt_s  = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (end_s) begin
                    ptr_nxt_s     = idx_r + 1'b1;
                    preempt_nxt_s = !release_i;
                    if (pick_s[SEL_WIDTH]) begin
                        state_nxt_s = BUSY;
                        idx_nxt_s   = pick_s[SEL_WIDTH-1:0];
                        valid_nxt_s = 1'b1;
                        hold_nxt_s  = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        state_nxt_s = IDLE;
                        idx_nxt_s   = {SEL_WIDTH{1'b0}};
                        valid_nxt_s = 1'b0;
                        hold_nxt_s  = {HOLD_WIDTH{1'b0}};
                    end
                end else if (hold_r != HOLD_SAT_C) begin
                    hold_nxt_s = hold_r + 1'b1;
                end else begin
                    hold_nxt_s = hold_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = {SEL_WIDTH{1'b0}};
                valid_nxt_s = 1'b0;
                hold_nxt_s  = {HOLD_WIDTH{1'b0}};
            end
        endcase
    end

    // One-hot grant decode of the next owner, so the grant itself is a plain register.
    always_comb begin
        grant_nxt_s = {N{1'b0}};
        if (valid_nxt_s) begin
            grant_nxt_s[idx_nxt_s] = 1'b1;
        end else begin
            grant_nxt_s = {N{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= {SEL_WIDTH{1'b0}};
            hold_r    <= {HOLD_WIDTH{1'b0}};
            idx_r     <= {SEL_WIDTH{1'b0}};
            valid_r   <= 1'b0;
            grant_r   <= {N{1'b0}};
            preempt_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            hold_r    <= hold_nxt_s;
            idx_r     <= idx_nxt_s;
            valid_r   <= valid_nxt_s;
            grant_r   <= grant_nxt_s;
            preempt_r <= preempt_nxt_s;
        end
    end

    assign grant       = grant_r;
    assign grant_idx   = idx_r;
    assign grant_valid = valid_r;
    assign preempt     = preempt_r;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter, built with a 4-cycle hold timeout.
module tb_rr_grant_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       release_i;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    int errors;
    int checks;

    rr_grant_arbiter #(.SEL_WIDTH(2), .MAX_HOLD(4), .HOLD_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .req(req), .release_i(release_i),
        .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; release_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Packed view: {grant, grant_idx, grant_valid, preempt}
    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b1; req = 4'b1111; release_i = 1'b0;
        tick(); tick();
        exp = {4'b0000, 2'd0, 1'b0, 1'b0};
        checks++;
        if ({grant, grant_idx, grant_valid, preempt} !== exp) begin
            errors++; $display("FAIL reset_hold got=%b exp=%b", {grant, grant_idx, grant_valid, preempt}, exp);
        end
        rst = 1'b0;
        tick();
        exp = {4'b0001, 2'd0, 1'b1, 1'b0};
        checks++;
        if ({grant, grant_idx, grant_valid, preempt} !== exp) begin
            errors++; $display("FAIL reset_first_grant got=%b exp=%b", {grant, grant_idx, grant_valid, preempt}, exp);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [4];
        logic [1:0] exp_i [4];
        exp_g[0] = 4'b0010; exp_g[1] = 4'b0100; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
        exp_i[0] = 2'd1;    exp_i[1] = 2'd2;    exp_i[2] = 2'd3;    exp_i[3] = 2'd0;
        req = 4'b1111; release_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({grant, grant_idx, grant_valid, preempt} !== {exp_g[i], exp_i[i], 1'b1, 1'b0}) begin
                errors++; $display("FAIL rotation_%0d got=%b exp=%b", i,
                    {grant, grant_idx, grant_valid, preempt}, {exp_g[i], exp_i[i], 1'b1, 1'b0});
            end
        end
        release_i = 1'b0;
    endtask

    task automatic test_single_regrant();
        do_reset();
        req = 4'b0100;
        tick(); tick(); tick();
        checks++;
        if ({grant, grant_idx, grant_valid, preempt} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL single_held got=%b exp=%b", {grant, grant_idx, grant_valid, preempt}, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
        release_i = 1'b1;
        tick();
        checks++;
        if ({grant, grant_idx, grant_valid, preempt} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL single_regrant got=%b exp=%b", {grant, grant_idx, grant_valid, preempt}, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
        // Pointer should now sit at 3, so a full request set picks index 3 next.
        req = 4'b1111;
        tick();
        checks++;
        if ({grant, grant_idx, grant_valid, preempt} !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL single_ptr got=%b exp=%b", {grant, grant_idx, grant_valid, preempt}, {4'b1000, 2'd3, 1'b1, 1'b0});
        end
        release_i = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({grant, grant_idx, grant_valid, preempt} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
                errors++; $display("FAIL timeout_hold_%0d got=%b exp=%b", i,
                    {grant, grant_idx, grant_valid, preempt}, {4'b0001, 2'd0, 1'b1, 1'b0});
            end
        end
        tick();
        checks++;
        if ({grant, grant_idx, grant_valid, preempt} !== {4'b0010, 2'd1, 1'b1, 1'b1}) begin
            errors++; $display("FAIL timeout_preempt got=%b exp=%b", {grant, grant_idx, grant_valid, preempt}, {4'b0010, 2'd1, 1'b1, 1'b1});
        end
        tick();
        checks++;
        if ({grant, grant_idx, grant_valid, preempt} !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL timeout_pulse_end got=%b exp=%b", {grant, grant_idx, grant_valid, preempt}, {4'b0010, 2'd1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_release_timeout_coincide();
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick(); tick(); tick();
        // Owner dropped req but still holds; hold has reached 4 this cycle.
        checks++;
        if ({grant, grant_idx, grant_valid, preempt} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL coincide_held got=%b exp=%b", {grant, grant_idx, grant_valid, preempt}, {4'b0001, 2'd0, 1'b1, 1'b0});
        end
        release_i = 1'b1;
        tick();
        checks++;
        if ({grant, grant_valid, preempt} !== {4'b0000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL coincide_idle got=%b exp=%b", {grant, grant_valid, preempt}, {4'b0000, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if ({grant, grant_valid, preempt} !== {4'b0000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL idle_release_ignored got=%b exp=%b", {grant, grant_valid, preempt}, {4'b0000, 1'b0, 1'b0});
        end
        release_i = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b1000;
        tick();
        checks++;
        if ({grant, grant_idx, grant_valid} !== {4'b1000, 2'd3, 1'b1}) begin
            errors++; $display("FAIL async_pre got=%b exp=%b", {grant, grant_idx, grant_valid}, {4'b1000, 2'd3, 1'b1});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({grant, grant_idx, grant_valid, preempt} !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_clear got=%b exp=%b", {grant, grant_idx, grant_valid, preempt}, {4'b0000, 2'd0, 1'b0, 1'b0});
        end
        tick();
        rst = 1'b0; req = 4'b1001;
        tick();
        checks++;
        if ({grant, grant_idx, grant_valid, preempt} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL async_after got=%b exp=%b", {grant, grant_idx, grant_valid, preempt}, {4'b0001, 2'd0, 1'b1, 1'b0});
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; req = 4'b0000; release_i = 1'b0;
        test_reset();
        test_rotation();
        test_single_regrant();
        test_timeout();
        test_release_timeout_coincide();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
